// File: rtl/tran_to_net_packetizer_if.sv
// Transport-side input and network-side output bundle of the packetizer.
// The slave modport is taken by the packetizer; the master modport is the environment.
interface tran_to_net_packetizer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
);
    logic [DATA_W-1:0] data;
    logic              sending;
    logic              net_ready;
    logic              pkt_valid;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_first;
    logic              pkt_last;
    logic              send_req;
    logic [DATA_W-1:0] phone_num;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        drop_count;

    modport master (
        output data, sending, net_ready,
        input  pkt_valid, pkt_data, pkt_first, pkt_last, send_req,
               phone_num, fifo_count, fifo_empty, fifo_full, drop_count
    );

    modport slave (
        input  data, sending, net_ready,
        output pkt_valid, pkt_data, pkt_first, pkt_last, send_req,
               phone_num, fifo_count, fifo_empty, fifo_full, drop_count
    );
endinterface

// File: rtl/tran_to_net_packetizer.sv
// Transport-to-network packetizer: bursts (phone + payload) are buffered and
// re-emitted as header + payload (+ optional pad) packets over valid/ready.
module tran_to_net_packetizer #(
    parameter int                DATA_W     = 8,
    parameter int                PKT_SIZE   = 16,
    parameter int                FIFO_DEPTH = 64,
    parameter int                CNT_W      = 7,
    parameter int                PAD_EN     = 1,
    parameter logic [DATA_W-1:0] PAD_VALUE  = '0
) (
    input logic                     clk,
    input logic                     reset,
    tran_to_net_packetizer_if.slave bus
);
    localparam int                LEN_W    = $clog2(PKT_SIZE + 1);
    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(PKT_SIZE);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {I_IDLE, I_PAY, I_GAP} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_HDR, O_PAY, O_PAD} out_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    in_state_t         i_state, i_next;
    out_state_t        o_state, o_next;

    logic [LEN_W-1:0]  in_cnt, cnt_inc, close_len;
    logic [DATA_W-1:0] in_phone;
    logic              start, push, close, drop;

    logic              pend_valid;
    logic [LEN_W-1:0]  pend_len;
    logic [DATA_W-1:0] pend_phone;
    logic              take, slot_free;

    logic [LEN_W-1:0]  act_len, o_cnt;
    logic [DATA_W-1:0] phone_num;
    logic              pay_end, pad_end, pad_needed, pop;
    logic              pkt_valid, pkt_first, pkt_last;
    logic [DATA_W-1:0] pkt_data;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full, push_ok, pop_ok;
    logic [7:0]        drop_count;

    // Input stage: burst framing, descriptor hand-off and drop accounting
    assign slot_free = !pend_valid || take;
    assign cnt_inc   = in_cnt + LEN_W'(1);

    always_comb begin
        i_next    = i_state;
        start     = 1'b0;
        push      = 1'b0;
        close     = 1'b0;
        drop      = 1'b0;
        close_len = in_cnt;
        case (i_state)
            I_IDLE: begin
                if (bus.sending) begin
                    if (slot_free) begin
                        start  = 1'b1;
                        i_next = I_PAY;
                    end else begin
                        drop   = 1'b1;
                        i_next = I_GAP;
                    end
                end
            end
            I_PAY: begin
                if (bus.sending) begin
                    push = 1'b1;
                    if (cnt_inc == FULL_LEN) begin
                        close     = 1'b1;
                        close_len = cnt_inc;
                        i_next    = I_GAP;
                    end
                end else begin
                    // A phone-only burst leaves nothing to send and is silently discarded
                    close  = (in_cnt != '0);
                    i_next = I_IDLE;
                end
            end
            I_GAP: begin
                if (bus.sending) drop = 1'b1;
                else             i_next = I_IDLE;
            end
            default: i_next = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state    <= I_IDLE;
            in_cnt     <= '0;
            pend_valid <= 1'b0;
            pend_len   <= '0;
            drop_count <= '0;
        end else begin
            i_state <= i_next;
            if (start)     in_cnt <= '0;
            else if (push) in_cnt <= cnt_inc;
            // close only fires while pend_valid is low, so it never races take
            if (close) begin
                pend_valid <= 1'b1;
                pend_len   <= close_len;
            end else if (take) begin
                pend_valid <= 1'b0;
            end
            if (drop) drop_count <= sat_inc(drop_count);
        end
    end

    always_ff @(posedge clk) begin
        if (start) in_phone   <= bus.data;
        if (close) pend_phone <= in_phone;
    end

    // Output stage: header, payload and pad beats
    assign pay_end    = (o_cnt == act_len - LEN_W'(1));
    assign pad_end    = (o_cnt == FULL_LEN - LEN_W'(1));
    assign pad_needed = (PAD_EN != 0) && (act_len < FULL_LEN);

    always_comb begin
        o_next    = o_state;
        take      = 1'b0;
        pop       = 1'b0;
        pkt_valid = 1'b0;
        pkt_first = 1'b0;
        pkt_last  = 1'b0;
        pkt_data  = '0;
        case (o_state)
            O_IDLE: begin
                if (pend_valid) begin
                    take   = 1'b1;
                    o_next = O_HDR;
                end
            end
            O_HDR: begin
                pkt_valid = 1'b1;
                pkt_first = 1'b1;
                pkt_data  = phone_num;
                if (bus.net_ready) o_next = O_PAY;
            end
            O_PAY: begin
                pkt_valid = 1'b1;
                pkt_data  = mem[rd_ptr];
                pkt_last  = pay_end && !pad_needed;
                if (bus.net_ready) begin
                    pop = 1'b1;
                    if (pay_end) o_next = pad_needed ? O_PAD : O_IDLE;
                end
            end
            O_PAD: begin
                pkt_valid = 1'b1;
                pkt_data  = PAD_VALUE;
                pkt_last  = pad_end;
                if (bus.net_ready && pad_end) o_next = O_IDLE;
            end
            default: o_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_state   <= O_IDLE;
            o_cnt     <= '0;
            act_len   <= '0;
            phone_num <= '0;
        end else begin
            o_state <= o_next;
            if (take) begin
                act_len   <= pend_len;
                phone_num <= pend_phone;
            end
            // o_cnt keeps running through the pad so pad_end lands on PKT_SIZE beats
            if (o_state == O_HDR && bus.net_ready)
                o_cnt <= '0;
            else if ((o_state == O_PAY || o_state == O_PAD) && bus.net_ready)
                o_cnt <= o_cnt + LEN_W'(1);
        end
    end

    // Payload FIFO
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign push_ok    = push && !fifo_full;
    assign pop_ok     = pop && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop_ok && !push_ok) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    assign bus.pkt_valid  = pkt_valid;
    assign bus.pkt_data   = pkt_data;
    assign bus.pkt_first  = pkt_first;
    assign bus.pkt_last   = pkt_last;
    assign bus.send_req   = pend_valid || (o_state != O_IDLE);
    assign bus.phone_num  = phone_num;
    assign bus.fifo_count = fifo_count;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_tran_to_net_packetizer.sv
// Directed scoreboard bench: a padding and a non-padding packetizer see identical stimulus.
module tb_tran_to_net_packetizer;
    localparam int DATA_W     = 8;
    localparam int PKT_SIZE   = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int CNT_W      = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tran_to_net_packetizer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bp ();
    tran_to_net_packetizer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bn ();

    tran_to_net_packetizer #(
        .DATA_W(DATA_W), .PKT_SIZE(PKT_SIZE), .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W), .PAD_EN(1), .PAD_VALUE(8'h00)
    ) dut (.clk(clk), .reset(reset), .bus(bp.slave));

    tran_to_net_packetizer #(
        .DATA_W(DATA_W), .PKT_SIZE(PKT_SIZE), .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W), .PAD_EN(0), .PAD_VALUE(8'h00)
    ) dut_np (.clk(clk), .reset(reset), .bus(bn.slave));

    assign bn.data      = bp.data;
    assign bn.sending   = bp.sending;
    assign bn.net_ready = bp.net_ready;

    int checks = 0;
    int errors = 0;
    logic [9:0] q_pad[$];
    logic [9:0] q_np[$];
    logic [7:0] pay_buf [0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats are {first, last, data}
    task automatic expect_pkt(input logic [7:0] phone, input int len);
        q_pad.push_back({2'b10, phone});
        q_np.push_back({2'b10, phone});
        for (int i = 0; i < len; i++) begin
            q_np.push_back({1'b0, (i == len - 1), pay_buf[i]});
            q_pad.push_back({1'b0, (i == len - 1) && (len >= PKT_SIZE), pay_buf[i]});
        end
        for (int i = len; i < PKT_SIZE; i++)
            q_pad.push_back({1'b0, (i == PKT_SIZE - 1), 8'h00});
    endtask

    task automatic drive_burst(input logic [7:0] phone, input int len);
        bp.sending = 1'b1;
        bp.data    = phone;
        tick();
        for (int i = 0; i < len; i++) begin
            bp.data = pay_buf[i];
            tick();
        end
        bp.sending = 1'b0;
        bp.data    = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q_pad.size() != 0 || q_np.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending_beats", 32'(q_pad.size() + q_np.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q_pad.delete();
        q_np.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (reset && bp.pkt_valid && bp.net_ready) begin
            check("pad_beat_expected", 32'(q_pad.size() != 0), 32'd1);
            if (q_pad.size() != 0) begin
                e = q_pad.pop_front();
                check("pad_beat", {22'b0, bp.pkt_first, bp.pkt_last, bp.pkt_data}, {22'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (reset && bn.pkt_valid && bn.net_ready) begin
            check("nopad_beat_expected", 32'(q_np.size() != 0), 32'd1);
            if (q_np.size() != 0) begin
                e = q_np.pop_front();
                check("nopad_beat", {22'b0, bn.pkt_first, bn.pkt_last, bn.pkt_data}, {22'b0, e});
            end
        end
    end

    initial begin
        logic [7:0] phones [0:2];
        logic [7:0] bases  [0:2];
        int b, off;

        bp.data      = '0;
        bp.sending   = 1'b0;
        bp.net_ready = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_pkt_valid", 32'(bp.pkt_valid), 32'd0);
        check("rst_send_req", 32'(bp.send_req), 32'd0);
        check("rst_fifo_count", 32'(bp.fifo_count), 32'd0);
        check("rst_fifo_empty", 32'(bp.fifo_empty), 32'd1);
        check("rst_phone_num", 32'(bp.phone_num), 32'd0);
        check("rst_drop_count", 32'(bp.drop_count), 32'd0);
        reset = 1'b1;
        tick();

        // 1: full packet, header latency
        for (int i = 0; i < 16; i++) pay_buf[i] = 8'(i + 1);
        expect_pkt(8'h42, 16);
        drive_burst(8'h42, 16);
        check("t1_hdr_not_yet", 32'(bp.pkt_valid), 32'd0);
        tick();
        check("t1_hdr_valid", {bp.pkt_valid, bp.pkt_first, bp.pkt_data}, {22'b0, 2'b11, 8'h42});
        wait_drain(100);
        check("t1_phone_num", 32'(bp.phone_num), 32'h42);
        check("t1_drop_count", 32'(bp.drop_count), 32'd0);
        check("t1_fifo_empty", 32'(bp.fifo_empty), 32'd1);
        check("t1_send_req", 32'(bp.send_req), 32'd0);

        // 2: short packet, padded vs unpadded
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hA2; pay_buf[2] = 8'hA3;
        expect_pkt(8'h07, 3);
        drive_burst(8'h07, 3);
        wait_drain(100);
        check("t2_phone_num_nopad", 32'(bn.phone_num), 32'h07);
        check("t2_fifo_empty_nopad", 32'(bn.fifo_empty), 32'd1);

        // 3: backpressure, third burst finds the descriptor slot busy
        do_reset();
        phones[0] = 8'h11; phones[1] = 8'h22; phones[2] = 8'h33;
        bases[0]  = 8'h80; bases[1]  = 8'h90; bases[2]  = 8'hA0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) pay_buf[i] = bases[p] + 8'(i);
            expect_pkt(phones[p], 16);
        end
        for (int cyc = 0; cyc < 53; cyc++) begin
            if (cyc == 35) begin
                check("t3_fifo_count", 32'(bp.fifo_count), 32'd32);
                check("t3_fifo_full", 32'(bp.fifo_full), 32'd0);
                check("t3_send_req", 32'(bp.send_req), 32'd1);
            end
            bp.net_ready = (cyc >= 40);
            b   = cyc / 18;
            off = cyc % 18;
            if (off == 17) begin
                bp.sending = 1'b0;
                bp.data    = '0;
            end else begin
                bp.sending = 1'b1;
                bp.data    = (off == 0) ? phones[b] : bases[b] + 8'(off - 1);
            end
            tick();
        end
        bp.sending = 1'b0;
        bp.data    = '0;
        wait_drain(200);
        check("t3_drop_count", 32'(bp.drop_count), 32'd17);
        check("t3_drop_count_nopad", 32'(bn.drop_count), 32'd17);
        check("t3_fifo_empty", 32'(bp.fifo_empty), 32'd1);

        // 4: overlong burst is truncated
        do_reset();
        for (int i = 0; i < 19; i++) pay_buf[i] = 8'h60 + 8'(i);
        expect_pkt(8'h55, 16);
        drive_burst(8'h55, 19);
        wait_drain(100);
        check("t4_drop_count", 32'(bp.drop_count), 32'd3);
        check("t4_phone_num", 32'(bp.phone_num), 32'h55);

        // 5: phone-only burst
        do_reset();
        drive_burst(8'h99, 0);
        for (int i = 0; i < 6; i++) begin
            check("t5_send_req", 32'(bp.send_req), 32'd0);
            check("t5_pkt_valid", 32'(bp.pkt_valid), 32'd0);
            tick();
        end
        check("t5_drop_count", 32'(bp.drop_count), 32'd0);
        check("t5_fifo_empty", 32'(bp.fifo_empty), 32'd1);

        // 6: asynchronous reset mid-payload, then recovery
        for (int i = 0; i < 16; i++) pay_buf[i] = 8'hC0 + 8'(i);
        expect_pkt(8'hC3, 16);
        drive_burst(8'hC3, 16);
        for (int i = 0; i < 6; i++) tick();
        #2;
        reset = 1'b0;
        q_pad.delete();
        q_np.delete();
        #1;
        check("t6_pkt_valid", 32'(bp.pkt_valid), 32'd0);
        check("t6_pkt_flags", {bp.pkt_first, bp.pkt_last}, 32'd0);
        check("t6_pkt_data", 32'(bp.pkt_data), 32'd0);
        check("t6_send_req", 32'(bp.send_req), 32'd0);
        check("t6_fifo_count", 32'(bp.fifo_count), 32'd0);
        check("t6_fifo_empty", 32'(bp.fifo_empty), 32'd1);
        check("t6_phone_num", 32'(bp.phone_num), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) pay_buf[i] = 8'hE0 + 8'(i);
        expect_pkt(8'hD4, 5);
        drive_burst(8'hD4, 5);
        wait_drain(100);
        check("t6_phone_num_after", 32'(bp.phone_num), 32'hD4);
        check("t6_drop_after", 32'(bp.drop_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
